// File: rtl/video_to_fifo_ctrl_if.sv
// Bundles the video input, DDR write-FIFO and AXI burst-request signals of video_to_fifo_ctrl.
// The slave modport is the controller's view; the master modport is the surrounding system's view.
interface video_to_fifo_ctrl_if;
  logic         video_vs_in;
  logic         video_hs_in;
  logic         video_de_in;
  logic [23:0]  video_data_in;
  logic [127:0] fifo_data_out;
  logic         fifo_wr_en;
  logic         fifo_full;
  logic         AXI_FULL_BURST_VALID;
  logic         AXI_FULL_BURST_READY;
  logic         overflow;

  modport slave (
    input  video_vs_in, video_hs_in, video_de_in, video_data_in,
    input  fifo_full, AXI_FULL_BURST_READY,
    output fifo_data_out, fifo_wr_en, AXI_FULL_BURST_VALID, overflow
  );

  modport master (
    output video_vs_in, video_hs_in, video_de_in, video_data_in,
    output fifo_full, AXI_FULL_BURST_READY,
    input  fifo_data_out, fifo_wr_en, AXI_FULL_BURST_VALID, overflow
  );
endinterface

// File: rtl/video_to_fifo_ctrl.sv
// Packs a 24-bit RGB stream into 128-bit DDR write-FIFO words and requests one AXI burst
// per BURST_WORDS written words. Define VIDEO_WR_LINE_FLUSH_EN to flush partial words at line end.
module video_to_fifo_ctrl #(
  parameter int BURST_WORDS = 16,
  parameter int PEND_W      = 4
) (
  input logic                 video_clk,
  input logic                 video_rst_n,
  video_to_fifo_ctrl_if.slave bus
);

  localparam int                WCNT_W    = $clog2(BURST_WORDS);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(BURST_WORDS - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;

  typedef enum logic {WAIT_FRAME, ACTIVE} state_e;

  state_e            state_q, state_d;
  logic              vs_q, vsDly_q, de_q;
  logic [23:0]       pixel_q;
  logic [1:0]        laneCnt_q, laneCnt_d;
  logic [127:0]      pack_q, pack_d;
  logic              wordRdy_q, wordRdy_d;
  logic              wrPend_q;
  logic [127:0]      fifoData_q, fifoData_d;
  logic [WCNT_W-1:0] wordCnt_q, wordCnt_d;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic              overflow_q, overflow_d;
  logic              frameStart, wrFire, burstValid, pendInc, pendDec;
  logic              unusedHs;
`ifdef VIDEO_WR_LINE_FLUSH_EN
  logic              deDly_q;
  logic              deFall;
`endif

  assign unusedHs   = bus.video_hs_in;
  assign frameStart = vsDly_q & ~vs_q;
  assign wrFire     = wrPend_q & ~bus.fifo_full;
  assign burstValid = (pending_q != '0);
  assign pendDec    = burstValid & bus.AXI_FULL_BURST_READY;
`ifdef VIDEO_WR_LINE_FLUSH_EN
  assign deFall     = deDly_q & ~de_q;
`endif

  always_ff @(posedge video_clk) begin
    if (!video_rst_n) begin
      state_q    <= WAIT_FRAME;
      vs_q       <= 1'b0;
      vsDly_q    <= 1'b0;
      de_q       <= 1'b0;
      pixel_q    <= '0;
      laneCnt_q  <= '0;
      pack_q     <= '0;
      wordRdy_q  <= 1'b0;
      wrPend_q   <= 1'b0;
      fifoData_q <= '0;
      wordCnt_q  <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
`ifdef VIDEO_WR_LINE_FLUSH_EN
      deDly_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      vs_q       <= bus.video_vs_in;
      vsDly_q    <= vs_q;
      de_q       <= bus.video_de_in;
      pixel_q    <= bus.video_data_in;
      laneCnt_q  <= laneCnt_d;
      pack_q     <= pack_d;
      wordRdy_q  <= wordRdy_d;
      wrPend_q   <= wordRdy_q;
      fifoData_q <= fifoData_d;
      wordCnt_q  <= wordCnt_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
`ifdef VIDEO_WR_LINE_FLUSH_EN
      deDly_q    <= de_q;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    laneCnt_d  = laneCnt_q;
    pack_d     = pack_q;
    wordRdy_d  = 1'b0;
    fifoData_d = fifoData_q;
    wordCnt_d  = wordCnt_q;
    pending_d  = pending_q;
    overflow_d = overflow_q;
    pendInc    = 1'b0;

    // Frame start wins over a pixel or line end landing in the same cycle.
    case (state_q)
      WAIT_FRAME: begin
        if (frameStart) begin
          state_d   = ACTIVE;
          laneCnt_d = '0;
        end
      end
      ACTIVE: begin
        if (frameStart) begin
          laneCnt_d = '0;
        end else if (de_q) begin
          laneCnt_d = laneCnt_q + 2'd1;
          case (laneCnt_q)
            2'd0: pack_d = {8'h00, pixel_q, 96'h0};
            2'd1: pack_d[87:64] = pixel_q;
            2'd2: pack_d[55:32] = pixel_q;
            default: begin
              pack_d[23:0] = pixel_q;
              wordRdy_d    = 1'b1;
            end
          endcase
        end
`ifdef VIDEO_WR_LINE_FLUSH_EN
        else if (deFall && laneCnt_q != 2'd0) begin
          wordRdy_d = 1'b1;
          laneCnt_d = '0;
        end
`endif
      end
      default: state_d = WAIT_FRAME;
    endcase

    if (wordRdy_q) begin
      fifoData_d = pack_q;
    end

    // A dropped word does not count toward burst alignment.
    if (wrPend_q && bus.fifo_full) begin
      overflow_d = 1'b1;
    end
    if (wrFire) begin
      if (wordCnt_q == WCNT_LAST) begin
        wordCnt_d = '0;
        pendInc   = 1'b1;
      end else begin
        wordCnt_d = wordCnt_q + 1'b1;
      end
    end

    if (pendInc && !pendDec) begin
      if (pending_q == PEND_MAX) begin
        overflow_d = 1'b1;
      end else begin
        pending_d = pending_q + 1'b1;
      end
    end else if (!pendInc && pendDec) begin
      pending_d = pending_q - 1'b1;
    end
  end

  assign bus.fifo_data_out        = fifoData_q;
  assign bus.fifo_wr_en           = wrFire;
  assign bus.AXI_FULL_BURST_VALID = burstValid;
  assign bus.overflow             = overflow_q;

endmodule

// File: tb/tb_video_to_fifo_ctrl.sv
// Scoreboard bench for video_to_fifo_ctrl: a pixel-list reference model queues expected
// FIFO words with their due cycle; an independent monitor checks strobes, bursts and overflow.
`timescale 1ns/1ps
module tb_video_to_fifo_ctrl;
  localparam int BURST_WORDS = 16;
  localparam int PEND_W      = 4;
  localparam int PEND_MAX    = (1 << PEND_W) - 1;

  typedef struct {
    logic [127:0] word;
    int           due;
  } exp_t;

  logic videoClk = 1'b0;
  logic videoRstN;
  video_to_fifo_ctrl_if bus();

  video_to_fifo_ctrl #(.BURST_WORDS(BURST_WORDS), .PEND_W(PEND_W)) dut (
    .video_clk  (videoClk),
    .video_rst_n(videoRstN),
    .bus        (bus)
  );

  always #5 videoClk = ~videoClk;

  int cyc = 0;
  always @(posedge videoClk) cyc <= cyc + 1;

  exp_t        expQ[$];
  logic [23:0] parts[$];
  bit          frameActive, prevVs, prevDe;
  int          expPend, expWordCnt;
  bit          expOvf, monEn;
  int          vectors = 0;
  int          miscompares = 0;

  exp_t monItem;
  bit   monLanded, monDec, monInc, monOvfSet;

  function automatic logic [127:0] packWord(input logic [23:0] p0, p1, p2, p3);
    return {8'h00, p0, 8'h00, p1, 8'h00, p2, 8'h00, p3};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
    end
  endtask

  // One cycle of video input plus the reference model's view of what that cycle means.
  task automatic applyStimulus(input logic vs, input logic de, input logic [23:0] px,
                               input logic rdy, input logic full);
    logic [23:0] l [4];
    @(posedge videoClk);
    #1;
    bus.video_vs_in          = vs;
    bus.video_hs_in          = 1'($urandom_range(0, 1));
    bus.video_de_in          = de;
    bus.video_data_in        = px;
    bus.AXI_FULL_BURST_READY = rdy;
    bus.fifo_full            = full;
    if (!frameActive) begin
      if (prevVs && !vs) begin
        frameActive = 1'b1;
        parts.delete();
      end
    end else if (prevVs && !vs) begin
      parts.delete();
    end else if (de) begin
      parts.push_back(px);
      if (parts.size() == 4) begin
        expQ.push_back('{word: packWord(parts[0], parts[1], parts[2], parts[3]), due: cyc + 3});
        parts.delete();
      end
    end
`ifdef VIDEO_WR_LINE_FLUSH_EN
    else if (prevDe && parts.size() != 0) begin
      for (int i = 0; i < 4; i++) l[i] = (i < parts.size()) ? parts[i] : 24'h0;
      expQ.push_back('{word: packWord(l[0], l[1], l[2], l[3]), due: cyc + 3});
      parts.delete();
    end
`endif
    prevVs = vs;
    prevDe = de;
  endtask

  task automatic idleCycles(input int n, input logic rdy, input logic full);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 24'h0, rdy, full);
  endtask

  task automatic sendPixels(input int n, input logic full);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 24'($urandom), 1'b0, full);
  endtask

  task automatic vsPulse();
    applyStimulus(1'b1, 1'b0, 24'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 24'h0, 1'b0, 1'b0);
    idleCycles(2, 1'b0, 1'b0);
  endtask

  task automatic resetDut();
    @(posedge videoClk);
    #1;
    monEn                    = 1'b0;
    videoRstN                = 1'b0;
    bus.video_vs_in          = 1'b0;
    bus.video_hs_in          = 1'b0;
    bus.video_de_in          = 1'b0;
    bus.video_data_in        = 24'h0;
    bus.AXI_FULL_BURST_READY = 1'b0;
    bus.fifo_full            = 1'b0;
    repeat (2) @(posedge videoClk);
    @(negedge videoClk);
    checkOutput("reset_data",     bus.fifo_data_out, 128'h0);
    checkOutput("reset_wr_en",    128'(bus.fifo_wr_en), 128'h0);
    checkOutput("reset_valid",    128'(bus.AXI_FULL_BURST_VALID), 128'h0);
    checkOutput("reset_overflow", 128'(bus.overflow), 128'h0);
    expQ.delete();
    parts.delete();
    frameActive = 1'b0;
    prevVs      = 1'b0;
    prevDe      = 1'b0;
    expPend     = 0;
    expWordCnt  = 0;
    expOvf      = 1'b0;
    @(posedge videoClk);
    #1;
    videoRstN = 1'b1;
    monEn     = 1'b1;
  endtask

  // Monitor: checks the write strobe against due words, then advances burst/overflow expectations.
  always @(negedge videoClk) begin
    if (monEn) begin
      monLanded = 1'b0;
      monOvfSet = 1'b0;
      checkOutput("burst_valid", 128'(bus.AXI_FULL_BURST_VALID), 128'(expPend != 0));
      checkOutput("overflow", 128'(bus.overflow), 128'(expOvf));
      if (expQ.size() != 0 && expQ[0].due == cyc) begin
        monItem = expQ.pop_front();
        if (bus.fifo_full) begin
          checkOutput("dropped_wr_en", 128'(bus.fifo_wr_en), 128'h0);
          monOvfSet = 1'b1;
        end else begin
          checkOutput("wr_en", 128'(bus.fifo_wr_en), 128'h1);
          checkOutput("fifo_word", bus.fifo_data_out, monItem.word);
          monLanded = 1'b1;
        end
      end else begin
        checkOutput("idle_wr_en", 128'(bus.fifo_wr_en), 128'h0);
      end
      monDec = (expPend != 0) && bus.AXI_FULL_BURST_READY;
      monInc = monLanded && (expWordCnt == BURST_WORDS - 1);
      if (monLanded) expWordCnt = (expWordCnt + 1) % BURST_WORDS;
      if (monInc && !monDec) begin
        if (expPend == PEND_MAX) monOvfSet = 1'b1;
        else expPend++;
      end else if (monDec && !monInc) begin
        expPend--;
      end
      if (monOvfSet) expOvf = 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    videoRstN = 1'b0;
    monEn     = 1'b0;
    resetDut();

    // Pixels before the first frame start are ignored.
    sendPixels(4, 1'b0);
    idleCycles(2, 1'b0, 1'b0);
    vsPulse();

    applyStimulus(1'b0, 1'b1, 24'h111111, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 24'h222222, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 24'h333333, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 24'h444444, 1'b0, 1'b0);
    idleCycles(4, 1'b0, 1'b0);
    sendPixels(8, 1'b0);
    idleCycles(4, 1'b0, 1'b0);

    // Complete the first burst with READY low, then a single-cycle handshake.
    sendPixels(13 * 4, 1'b0);
    idleCycles(6, 1'b0, 1'b0);
    idleCycles(1, 1'b1, 1'b0);
    idleCycles(3, 1'b0, 1'b0);

    // Next burst boundary lands exactly on a handshake while one request is pending.
    sendPixels(16 * 4, 1'b0);
    sendPixels(15 * 4, 1'b0);
    sendPixels(4, 1'b0);
    idleCycles(2, 1'b0, 1'b0);
    idleCycles(1, 1'b1, 1'b0);
    idleCycles(3, 1'b0, 1'b0);
    idleCycles(1, 1'b1, 1'b0);
    idleCycles(3, 1'b0, 1'b0);

    // FIFO full while the second of two words is written.
    sendPixels(4, 1'b0);
    idleCycles(4, 1'b0, 1'b0);
    sendPixels(4, 1'b1);
    idleCycles(4, 1'b0, 1'b1);
    idleCycles(2, 1'b0, 1'b0);
    sendPixels(12, 1'b0);
    idleCycles(4, 1'b0, 1'b0);

    // Six-pixel line, then a continuation line.
    sendPixels(6, 1'b0);
    idleCycles(5, 1'b0, 1'b0);
    sendPixels(2, 1'b0);
    idleCycles(5, 1'b0, 1'b0);
    sendPixels(2, 1'b0);
    idleCycles(5, 1'b0, 1'b0);

    // Frame start coinciding with line end discards the partial word.
    sendPixels(2, 1'b0);
    applyStimulus(1'b1, 1'b1, 24'($urandom), 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 24'h0, 1'b0, 1'b0);
    idleCycles(2, 1'b0, 1'b0);
    sendPixels(4, 1'b0);
    idleCycles(5, 1'b0, 1'b0);

    for (int i = 0; i < 1500; i++) begin
      applyStimulus(1'($urandom_range(0, 149) == 0), 1'($urandom_range(0, 9) < 7),
                    24'($urandom), 1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 9) == 0));
    end
    idleCycles(6, 1'b0, 1'b0);

    // Saturate the pending counter with READY held low, then drain it.
    resetDut();
    vsPulse();
    sendPixels((PEND_MAX + 1) * BURST_WORDS * 4 + 16, 1'b0);
    idleCycles(4, 1'b0, 1'b0);
    idleCycles(PEND_MAX + 3, 1'b1, 1'b0);
    idleCycles(3, 1'b0, 1'b0);

    for (int i = 0; i < 10 && expQ.size() != 0; i++) @(posedge videoClk);
    vectors++;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d expected words still outstanding, required 0", expQ.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
